// File: rtl/accel_pkg.sv
// Shared types and constants for the accelerator host loader and its result reader.
package accel_pkg;

    localparam int unsigned PTR_DEPTH = 17;
    localparam int unsigned ACT_MAX   = 1024;
    localparam int unsigned RES_DEPTH = 16;

    localparam int unsigned PTR_W = 8;
    localparam int unsigned ACT_W = 12;
    localparam int unsigned RES_W = 32;

    localparam logic [4:0]  PTR_LAST  = 5'(PTR_DEPTH - 1);
    localparam logic [3:0]  RES_LAST  = 4'(RES_DEPTH - 1);
    localparam logic [10:0] ACT_MAX_L = 11'(ACT_MAX);

    typedef enum logic [3:0] {
        IDLE,
        LOAD_PTR,
        LOAD_ACT,
        KICK,
        WAIT,
        RD_ISSUE,
        RD_CAP,
        HOLD,
        FIN
    } state_t;

endpackage

// File: rtl/accel_result_reader.sv
// Walks the 16 result words out of mem2 (issue, capture, hold) and presents them
// on a valid/ready stream; pulses last_hs_o on the handshake of the final word.
module accel_result_reader
    import accel_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [RES_W-1:0] mem2_q1,
    output logic [3:0]       mem2_addr1,
    output logic             mem2_ce1,
    output logic             mem2_we1,
    output logic             out_valid,
    output logic [RES_W-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             last_hs_o
);

    state_t           phase_q, phase_d;
    logic [3:0]       res_cnt_q, res_cnt_d;
    logic [RES_W-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q   <= IDLE;
            res_cnt_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            res_cnt_q <= res_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
        end
    end

    always_comb begin
        phase_d   = phase_q;
        res_cnt_d = res_cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        last_d    = last_q;
        mem2_ce1  = 1'b0;
        last_hs_o = 1'b0;
        unique case (phase_q)
            RD_ISSUE: begin
                mem2_ce1 = 1'b1;
                phase_d  = RD_CAP;
            end
            // RAM data is valid the cycle after ce, so capture here
            RD_CAP: begin
                data_d  = mem2_q1;
                valid_d = 1'b1;
                last_d  = (res_cnt_q == RES_LAST);
                phase_d = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (last_q) begin
                        last_hs_o = 1'b1;
                        phase_d   = IDLE;
                    end else begin
                        res_cnt_d = res_cnt_q + 4'd1;
                        phase_d   = RD_ISSUE;
                    end
                end
            end
            default: begin
                if (start_i) begin
                    res_cnt_d = '0;
                    phase_d   = RD_ISSUE;
                end
            end
        endcase
    end

    assign mem2_addr1 = res_cnt_q;
    assign mem2_we1   = 1'b0;
    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign out_last   = last_q;

endmodule

// File: rtl/accel_host_loader.sv
// Host sequencer: loads pointer/activation buffers, kicks the accelerator, drains results.
// Optional WAIT watchdog enabled by defining ACCEL_WATCHDOG_EN.
module accel_host_loader
    import accel_pkg::*;
`ifdef ACCEL_WATCHDOG_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 65535
)
`endif
(
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [10:0]      act_len,
    input  logic             in_valid,
    input  logic [ACT_W-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [RES_W-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             acc_start,
    input  logic             acc_finish,
    output logic [4:0]       mem0_addr1,
    output logic             mem0_ce1,
    output logic             mem0_we1,
    output logic [PTR_W-1:0] mem0_d1,
    output logic [9:0]       mem1_addr1,
    output logic             mem1_ce1,
    output logic             mem1_we1,
    output logic [ACT_W-1:0] mem1_d1,
    output logic [3:0]       mem2_addr1,
    output logic             mem2_ce1,
    output logic             mem2_we1,
    input  logic [RES_W-1:0] mem2_q1
);

    state_t      state_q, state_d;
    logic [10:0] len_q, len_d;
    logic [4:0]  ptr_cnt_q, ptr_cnt_d;
    logic [10:0] act_cnt_q, act_cnt_d;
    logic        rd_start;
    logic        rd_last_hs;

`ifdef ACCEL_WATCHDOG_EN
    logic [15:0] wdog_q, wdog_d;
    logic        err_q, err_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            len_q     <= '0;
            ptr_cnt_q <= '0;
            act_cnt_q <= '0;
`ifdef ACCEL_WATCHDOG_EN
            wdog_q    <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            ptr_cnt_q <= ptr_cnt_d;
            act_cnt_q <= act_cnt_d;
`ifdef ACCEL_WATCHDOG_EN
            wdog_q    <= wdog_d;
            err_q     <= err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        ptr_cnt_d = ptr_cnt_q;
        act_cnt_d = act_cnt_q;
        rd_start  = 1'b0;
        in_ready  = 1'b0;
        acc_start = 1'b0;
        done      = 1'b0;
        mem0_ce1  = 1'b0;
        mem0_we1  = 1'b0;
        mem0_d1   = '0;
        mem1_ce1  = 1'b0;
        mem1_we1  = 1'b0;
        mem1_d1   = '0;
`ifdef ACCEL_WATCHDOG_EN
        wdog_d    = wdog_q;
        err_d     = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (go) begin
                    len_d     = (act_len > ACT_MAX_L) ? ACT_MAX_L : act_len;
                    ptr_cnt_d = '0;
                    act_cnt_d = '0;
`ifdef ACCEL_WATCHDOG_EN
                    wdog_d    = '0;
                    err_d     = 1'b0;
`endif
                    state_d   = LOAD_PTR;
                end
            end
            LOAD_PTR: begin
                in_ready = 1'b1;
                mem0_d1  = in_data[PTR_W-1:0];
                if (in_valid) begin
                    mem0_ce1 = 1'b1;
                    mem0_we1 = 1'b1;
                    if (ptr_cnt_q == PTR_LAST) begin
                        state_d = (len_q == '0) ? KICK : LOAD_ACT;
                    end else begin
                        ptr_cnt_d = ptr_cnt_q + 5'd1;
                    end
                end
            end
            LOAD_ACT: begin
                in_ready = 1'b1;
                mem1_d1  = in_data;
                if (in_valid) begin
                    mem1_ce1 = 1'b1;
                    mem1_we1 = 1'b1;
                    if (act_cnt_q == len_q - 11'd1) begin
                        state_d = KICK;
                    end else begin
                        act_cnt_d = act_cnt_q + 11'd1;
                    end
                end
            end
            KICK: begin
                acc_start = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                if (acc_finish) begin
                    rd_start = 1'b1;
                    state_d  = RD_ISSUE;
                end
`ifdef ACCEL_WATCHDOG_EN
                else if (wdog_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    wdog_d = wdog_q + 16'd1;
                end
`endif
            end
            // Top parks here while the reader walks its own issue/capture/hold phases
            RD_ISSUE: begin
                if (rd_last_hs) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign mem0_addr1 = ptr_cnt_q;
    assign mem1_addr1 = act_cnt_q[9:0];

`ifdef ACCEL_WATCHDOG_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    accel_result_reader u_reader (
        .clk        (clk),
        .reset      (reset),
        .start_i    (rd_start),
        .mem2_q1    (mem2_q1),
        .mem2_addr1 (mem2_addr1),
        .mem2_ce1   (mem2_ce1),
        .mem2_we1   (mem2_we1),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .last_hs_o  (rd_last_hs)
    );

endmodule

// File: tb/tb_accel_host_loader.sv
// Self-checking bench for accel_host_loader: job table, randomized jobs, reset and WAIT corner cases.
`timescale 1ns/1ps
module tb_accel_host_loader;
    import accel_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        go = 1'b0;
    logic [10:0] act_len = '0;
    logic        in_valid = 1'b0;
    logic [11:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_ready = 1'b0;
    logic        busy, done, err, acc_start;
    logic        acc_finish = 1'b0;
    logic [4:0]  mem0_addr1;
    logic        mem0_ce1, mem0_we1;
    logic [7:0]  mem0_d1;
    logic [9:0]  mem1_addr1;
    logic        mem1_ce1, mem1_we1;
    logic [11:0] mem1_d1;
    logic [3:0]  mem2_addr1;
    logic        mem2_ce1, mem2_we1;
    logic [31:0] mem2_q1 = '0;

    always #5 clk = ~clk;

`ifdef ACCEL_WATCHDOG_EN
    accel_host_loader #(.TIMEOUT_CYCLES(100)) dut (
`else
    accel_host_loader dut (
`endif
        .clk(clk), .reset(reset), .go(go), .act_len(act_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .done(done), .err(err), .acc_start(acc_start), .acc_finish(acc_finish),
        .mem0_addr1(mem0_addr1), .mem0_ce1(mem0_ce1), .mem0_we1(mem0_we1), .mem0_d1(mem0_d1),
        .mem1_addr1(mem1_addr1), .mem1_ce1(mem1_ce1), .mem1_we1(mem1_we1), .mem1_d1(mem1_d1),
        .mem2_addr1(mem2_addr1), .mem2_ce1(mem2_ce1), .mem2_we1(mem2_we1), .mem2_q1(mem2_q1)
    );

    // Result RAM: read data appears the cycle after ce
    logic [31:0] res_mem [16];
    always @(posedge clk) if (mem2_ce1) mem2_q1 <= res_mem[mem2_addr1];

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct { int addr; int data; } wr_t;
    wr_t         m0_q[$];
    wr_t         m1_q[$];
    logic [31:0] outw_q[$];
    logic        outl_q[$];
    logic [11:0] beat_q[$];
    int cyc = 0, beats = 0, starts = 0, dones = 0, reads = 0, outv_cnt = 0;
    int last_beat_cyc = 0, start_cyc = 0, done_cyc = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    // Monitor samples mid-cycle, i.e. what the next rising edge will commit
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (in_valid && in_ready) begin beats++; last_beat_cyc = cyc; end
            if (mem0_ce1 && mem0_we1) m0_q.push_back('{int'(mem0_addr1), int'(mem0_d1)});
            if (mem1_ce1 && mem1_we1) m1_q.push_back('{int'(mem1_addr1), int'(mem1_d1)});
            if (mem2_ce1) reads++;
            if (acc_start) begin starts++; start_cyc = cyc; end
            if (done) begin dones++; done_cyc = cyc; end
            if (out_valid) outv_cnt++;
            if (prev_stall && out_valid) check("hold_data_stable", out_data, prev_data);
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (out_valid && out_ready) begin
                outw_q.push_back(out_data);
                outl_q.push_back(out_last);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        m0_q.delete(); m1_q.delete(); outw_q.delete(); outl_q.delete();
        beats = 0; starts = 0; dones = 0; reads = 0; outv_cnt = 0;
        prev_stall = 1'b0;
    endtask

    function automatic logic [127:0] all_outs();
        return {in_ready, out_valid, out_data, out_last, busy, done, err, acc_start,
                mem0_addr1, mem0_ce1, mem0_we1, mem0_d1, mem1_addr1, mem1_ce1, mem1_we1, mem1_d1,
                mem2_addr1, mem2_ce1, mem2_we1};
    endfunction

    task automatic feed(input int n, input bit rnd);
        int idx;
        int budget;
        idx = 0;
        budget = 6000;
        while (idx < n && budget > 0) begin
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = beat_q[idx];
            go       = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            if (rnd) act_len = 11'($urandom);
            if (in_valid && in_ready) idx++;
            tick();
            budget--;
        end
        go = 1'b0;
    endtask

    task automatic run_job(input int len, input int exp_beats, input int fin_dly,
                           input int bp_word, input int bp_cyc, input bit rnd);
        int budget;
        int stall;
        int n_act;
        clear_logs();
        n_act = exp_beats - 17;
        beat_q.delete();
        for (int i = 0; i < 16; i++) res_mem[i] = $urandom;
        for (int i = 0; i < 17; i++) beat_q.push_back(rnd ? 12'($urandom) : 12'(i));
        for (int i = 0; i < n_act; i++) beat_q.push_back(rnd ? 12'($urandom) : 12'(12'hA01 + i));
        act_len    = 11'(len);
        acc_finish = (fin_dly < 0);
        go = 1'b1;
        tick();
        go = 1'b0;
        feed(exp_beats, rnd);
        in_valid = 1'b1;
        in_data  = 12'hFFF;
        budget = 100;
        while (starts == 0 && budget > 0) begin tick(); budget--; end
        check("acc_start_seen", starts, 1);
        check("start_after_last_beat", start_cyc - last_beat_cyc, 1);
        for (int i = 0; i < fin_dly; i++) tick();
        acc_finish = 1'b1;
        stall = 0;
        budget = 3000;
        while (dones == 0 && budget > 0) begin
            if (reads > 0) acc_finish = 1'b0;
            if (bp_word >= 0 && out_valid && outw_q.size() == bp_word && stall < bp_cyc) begin
                out_ready = 1'b0;
                stall++;
            end else begin
                out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            tick();
            budget--;
        end
        in_valid = 1'b0; out_ready = 1'b0; acc_finish = 1'b0;
        repeat (3) tick();
        check("beats_accepted", beats, exp_beats);
        check("acc_start_count", starts, 1);
        check("mem0_write_count", m0_q.size(), 17);
        for (int i = 0; i < m0_q.size() && i < 17; i++) begin
            check($sformatf("mem0_addr[%0d]", i), m0_q[i].addr, i);
            check($sformatf("mem0_data[%0d]", i), m0_q[i].data, beat_q[i][7:0]);
        end
        check("mem1_write_count", m1_q.size(), n_act);
        for (int i = 0; i < m1_q.size() && i < n_act; i++) begin
            check($sformatf("mem1_addr[%0d]", i), m1_q[i].addr, i);
            check($sformatf("mem1_data[%0d]", i), m1_q[i].data, beat_q[17 + i]);
        end
        check("mem2_reads", reads, 16);
        check("mem2_we1", mem2_we1, 0);
        check("result_count", outw_q.size(), 16);
        for (int i = 0; i < outw_q.size() && i < 16; i++) begin
            check($sformatf("result[%0d]", i), outw_q[i], res_mem[i]);
            check($sformatf("last[%0d]", i), outl_q[i], (i == 15));
        end
        check("done_count", dones, 1);
        check("idle_after_job", {busy, out_valid, in_ready, err}, 0);
    endtask

    typedef struct {
        int len; int fin_dly; int bp_word; int bp_cyc; bit rnd; int exp_beats;
    } vec_t;
    vec_t tbl[6];

    initial begin
        int len;
        int eff;
        // {act_len, finish delay, stall word, stall cycles, random, expected accepted beats}
        tbl[0] = '{5,    20, -1, 0,  1'b0, 22};
        tbl[1] = '{0,    3,  -1, 0,  1'b0, 17};
        tbl[2] = '{2000, 1,  -1, 0,  1'b0, 1041};
        tbl[3] = '{7,    2,   3, 10, 1'b0, 24};
        tbl[4] = '{1024, -1, -1, 0,  1'b0, 1041};
        tbl[5] = '{1025, 0,   5, 4,  1'b1, 1041};

        repeat (3) tick();
        check("reset_outputs", all_outs(), 0);
        reset = 1'b0;
        tick();
        check("idle_after_reset", all_outs(), 0);

        for (int v = 0; v < 6; v++)
            run_job(tbl[v].len, tbl[v].exp_beats, tbl[v].fin_dly, tbl[v].bp_word, tbl[v].bp_cyc, tbl[v].rnd);

        for (int j = 0; j < 8; j++) begin
            len = (j == 0) ? int'($urandom_range(1000, 1100)) : int'($urandom_range(0, 40));
            eff = (len > int'(ACT_MAX)) ? int'(ACT_MAX) : len;
            run_job(len, 17 + eff, int'($urandom_range(0, 10)),
                    (j % 2 == 0) ? int'($urandom_range(0, 15)) : -1, int'($urandom_range(1, 8)), 1'b1);
        end

        // Reset in LOAD_ACT after the second activation beat
        clear_logs();
        beat_q.delete();
        for (int i = 0; i < 19; i++) beat_q.push_back(12'(12'h300 + i));
        act_len = 11'd5;
        go = 1'b1;
        tick();
        go = 1'b0;
        feed(19, 1'b0);
        in_valid = 1'b0;
        check("mid_reset_beats", beats, 19);
        reset = 1'b1;
        #2;
        check("mid_reset_outputs", all_outs(), 0);
        tick();
        reset = 1'b0;
        tick();
        check("mid_reset_no_done", dones, 0);
        run_job(5, 22, 4, -1, 0, 1'b0);

        // WAIT with acc_finish never asserted
        clear_logs();
        beat_q.delete();
        for (int i = 0; i < 17; i++) beat_q.push_back(12'(i));
        act_len = 11'd0;
        go = 1'b1;
        tick();
        go = 1'b0;
        feed(17, 1'b0);
        in_valid = 1'b0;
        repeat (150) tick();
        check("nofin_start", starts, 1);
`ifdef ACCEL_WATCHDOG_EN
        check("wd_done", dones, 1);
        check("wd_done_latency", done_cyc - start_cyc, 101);
        check("wd_err", err, 1);
        check("wd_no_out_valid", outv_cnt, 0);
        check("wd_no_reads", reads, 0);
        check("wd_idle", busy, 0);
`else
        check("wait_busy", busy, 1);
        check("wait_no_done", dones, 0);
        check("wait_no_reads", reads, 0);
        check("wait_no_out_valid", outv_cnt, 0);
        check("wait_err", err, 0);
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("recover_idle", all_outs(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/accel_host_loader.md
Name: accel_host_loader

Overview:
- Host-side sequencer feeding and draining the sparse CNN accelerator top level.
- Streams 17 activation index-pointer bytes into the pointer buffer (mem0) and activation CSR words into the input buffer (mem1), then pulses start and waits for finish.
- After finish, reads the 16 result words from the result RAM (mem2) and streams them out on a valid/ready interface.
- Sits directly upstream of the accelerator top level and drives all three of its external memory ports.

Parameters:
PTR_DEPTH, 17, pointer bytes loaded into mem0 (addresses 0..16)
ACT_MAX, 1024, maximum activation words accepted for mem1
RES_DEPTH, 16, result words read from mem2 (addresses 0..15)
TIMEOUT_CYCLES, 65535, watchdog limit in WAIT (used only with ACCEL_WATCHDOG_EN)

Ports:
clk  in  1  clock; single clock domain
reset  in  1  asynchronous, active-high reset
go  in  1  one-cycle request to begin a job; sampled in IDLE only
act_len  in  11  activation word count, latched on go
in_valid  in  1  input stream valid
in_data  in  12  input beat; bits [7:0] are used for pointer beats, [11:0] for activation beats
in_ready  out  1  input stream ready
out_valid  out  1  result stream valid
out_data  out  32  result word
out_last  out  1  high with the final (16th) result word
out_ready  in  1  result stream ready
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a job completes
err  out  1  sticky watchdog error; cleared on go
acc_start  out  1  one-cycle start pulse to the accelerator
acc_finish  in  1  accelerator finish
mem0_addr1/ce1/we1/d1  out  5/1/1/8  pointer buffer write port
mem1_addr1/ce1/we1/d1  out  10/1/1/12  input buffer write port
mem2_addr1/ce1/we1  out  4/1/1  result RAM read port (we1 is held 0)
mem2_q1  in  32  result RAM read data; valid one cycle after ce1

Behaviour:
- Reset values: every output is 0, state is IDLE, and all counters are 0. Reset asserted mid-job aborts immediately to IDLE; no partial done pulse is generated.
- Input stream: a beat is accepted only when in_valid and in_ready are both high.
- IDLE:
  - On go, latch act_len, clamped to ACT_MAX when above it.
  - Clear err and the counters, then enter LOAD_PTR.
  - go is ignored in every other state.
- LOAD_PTR:
  - in_ready = 1.
  - Each accepted beat drives mem0 in the same cycle with ce=we=1, addr=ptr_cnt, d=in_data[7:0].
  - ptr_cnt increments per beat.
  - After beat PTR_DEPTH-1, go to LOAD_ACT, or to KICK when act_len = 0.
- LOAD_ACT:
  - Each beat writes mem1 at addr=act_cnt with d=in_data.
  - After beat act_len-1, go to KICK.
  - in_ready is 0 in every other state, so extra beats are not consumed.
- KICK: acc_start = 1 for exactly one cycle, then enter WAIT.
- WAIT: hold until acc_finish = 1, then enter RD_ISSUE with res_cnt = 0. A finish already high on entry is accepted on the first WAIT cycle.
- RD_ISSUE: mem2_ce1 = 1 with addr=res_cnt, then enter RD_CAP.
- RD_CAP: register mem2_q1 into out_data, set out_valid = 1 and out_last = (res_cnt == RES_DEPTH-1), then enter HOLD.
- HOLD:
  - out_data stays stable while out_ready = 0.
  - On handshake, drop out_valid.
  - If last, go to FIN; otherwise increment res_cnt and go to RD_ISSUE.
  - Throughput is one word per 3 cycles minimum.
- FIN: done = 1 for one cycle, then return to IDLE.
- Memory ports: ce/we are 0 whenever no access occurs. Addresses are don't-care when ce = 0 but are held at their last value.
- Counter widths: ptr_cnt 5 bits, act_cnt 11 bits, res_cnt 4 bits. None of them wraps, because terminal compare happens before increment.

Optional Feature:
- ACCEL_WATCHDOG_EN defined:
  - A 16-bit counter runs in WAIT.
  - When it reaches TIMEOUT_CYCLES without acc_finish, set err = 1, skip readout and go to FIN (done still pulses).
- Undefined: no counter; err is tied 0; WAIT waits indefinitely.

Decomposition:
- Shared package accel_pkg holds:
  - the state enumeration (IDLE, LOAD_PTR, LOAD_ACT, KICK, WAIT, RD_ISSUE, RD_CAP, HOLD, FIN; 4-bit encoding);
  - the depth constants 17 / 1024 / 16;
  - the memory width constants 8 / 12 / 32.
- One natural sub-module, accel_result_reader, owns the RD_ISSUE/RD_CAP/HOLD sequencing and the output register. The top FSM hands it a start pulse and receives a last-handshake pulse.

Test Plan:
- Normal job:
  - Stimulus: go with act_len=5, 17 pointer beats 0x00..0x10, 5 act beats 0xA01..0xA05, acc_finish 20 cycles after acc_start.
  - Required: mem0[i]=i, mem1[0..4] written, a single acc_start pulse, 16 results out with out_last on the 16th, then done.
- act_len=0: no mem1 writes; acc_start follows the 17th pointer beat by one cycle.
- act_len=2000: clamped; exactly 1024 act beats accepted, in_ready falls after beat 1023.
- Backpressure: out_ready held 0 for 10 cycles on word 3; out_data is unchanged, mem2 is not re-read, and word order is preserved.
- Reset mid-LOAD_ACT (after beat 2): all outputs are 0 next edge; a following go restarts at mem0 addr 0.
- Watchdog:
  - With ACCEL_WATCHDOG_EN, TIMEOUT_CYCLES=100 and acc_finish never asserted: err=1, done pulses at cycle 100 of WAIT, and no out_valid.
  - Without the macro, the block stays in WAIT.
